l2_main_memory: RTL and testbench
=================================

Name: l2_main_memory

Overview:
- Block-granular backing-store model and controller; sits directly downstream of the L2 cache on its mem_* interface.
- Serves whole-block read (refill) and write (write-back) requests with a fixed, parameterised latency.
- Completes each request with a one-cycle ready pulse plus a hit flag.
- Used as the memory endpoint in L2 and full-hierarchy benches; synthesisable as a simple SRAM-backed controller.

Parameters:
DATA_WIDTH  32  bits per word
ADDR_WIDTH  32  byte-address width
BLOCK_SIZE  16  words per block; must match the L2 BLOCK_SIZE
MEM_BLOCKS  64  number of blocks stored
LATENCY  4  cycles from request capture to ready pulse, must be >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
mem_addr  in  ADDR_WIDTH  byte address of the request
mem_wdata  in  BLOCK_SIZE*DATA_WIDTH  write-back block; word j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
mem_read  in  1  block read request
mem_write  in  1  block write request
mem_rdata  out  BLOCK_SIZE*DATA_WIDTH  returned block
mem_ready  out  1  one-cycle completion pulse
mem_hit  out  1  address in range, valid while mem_ready=1
mem_busy  out  1  request in flight

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: mem_rdata=0, mem_ready=0, mem_hit=0, mem_busy=0, state=IDLE.
- Reset also initialises contents: word j of block b = b*BLOCK_SIZE + j.
- Address decode:
  - offset bits OFF = log2(BLOCK_SIZE)+2, which is 6 by default.
  - block index = mem_addr >> OFF; low OFF bits are ignored.
  - in range iff index < MEM_BLOCKS.
- State machine IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: on an edge where mem_read|mem_write=1, capture addr, op and wdata; load counter = LATENCY-1; go to BUSY; mem_busy=1 from the next cycle.
  - BUSY: decrement the counter each cycle. When counter==0, go to RESP.
  - With LATENCY=1, go straight to RESP on the following edge.
  - RESP: mem_ready=1 and mem_hit=in_range for exactly this cycle. Next state is IDLE with mem_busy=0.
- Latency: request sampled at edge N gives mem_ready=1 in the cycle after edge N+LATENCY.
- Read completion: if in range, mem_rdata is loaded with the stored block on the edge entering RESP. If out of range, mem_rdata=0.
- mem_rdata holds its value until the next read completion. Writes never change mem_rdata.
- Write completion: the captured wdata is committed to the array on the edge leaving RESP, and only if in range. Out-of-range writes are dropped.
- Simultaneous mem_read and mem_write in IDLE: treated as a write; the read is discarded.
- Requests while BUSY or RESP are ignored, not queued. Acceptance resumes in the first IDLE cycle after the pulse.
- Captured address and data are isolated from input changes after capture. The requester may drop its request after one cycle.
- Reset mid-operation: the in-flight request is aborted, no ready pulse is produced, no write is committed, and contents are reinitialised.
- Back-to-back: a request presented during the ready cycle is ignored. It must be re-presented or held into the following cycle.

Test Plan:
1. Reset, then read addr 0x40 pulsed 1 cycle at edge N -> mem_ready=1, mem_hit=1 in the cycle after edge N+4. mem_rdata word0=0x10, word15=0x1F. mem_busy is high for cycles N+1..N+4 only.
2. Write addr 0x80 with word j=0x1000+j, then read 0x80 -> the write gets a ready pulse with hit=1. The read returns word0=0x1000 and word15=0x100F. mem_rdata is unchanged by the write pulse.
3. Read 0x1000 (block 64, out of range) -> ready after 4 cycles, mem_hit=0, mem_rdata=0. A write to the same address is dropped, and a later read of 0x0 still returns word0=0x0.
4. Assert read and write together at 0xC0 with wdata=0xAAAA_AAAA in every word -> treated as a write. A subsequent read of 0xC0 returns 0xAAAA_AAAA in every word.
5. Present a second read 2 cycles into a busy read, and a request during the ready cycle -> both are ignored, giving exactly one ready pulse. A request held into the next IDLE cycle is accepted.
6. Issue a write to 0x40, then assert rst for 1 cycle at count 2 -> no ready pulse, and all outputs are 0. A read of 0x40 then returns the reset pattern word0=0x10.

Source files
------------

// File: rtl/l2_main_memory.sv
// Block-granular backing store behind the L2 mem_* port: whole-block refill reads and
// write-backs, each completed after a fixed latency with a one-cycle ready/hit pulse.
module l2_main_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int MEM_BLOCKS = 64,
  parameter int LATENCY    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
  input  logic                             mem_read,
  input  logic                             mem_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
  output logic                             mem_ready,
  output logic                             mem_hit,
  output logic                             mem_busy
);
  // state | meaning
  // IDLE  | accepting a request; read|write captures addr/op/wdata
  // BUSY  | latency countdown; terminal count moves to RESP
  // RESP  | ready/hit pulse; a pending write commits on the way out

  localparam int OFF = $clog2(BLOCK_SIZE) + 2;
  localparam int IW  = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int BW  = BLOCK_SIZE * DATA_WIDTH;
  // Range check against the full byte address, so any upper bit set means out of range.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_BLOCKS) << OFF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_write;
  logic          in_range;
  logic [IW-1:0] idx;
  logic [BW-1:0] wdata_q;
  logic [BW-1:0] mem [MEM_BLOCKS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_write  <= 1'b0;
      in_range  <= 1'b0;
      idx       <= '0;
      wdata_q   <= '0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      mem_hit   <= 1'b0;
      mem_busy  <= 1'b0;
      for (int b = 0; b < MEM_BLOCKS; b++)
        for (int j = 0; j < BLOCK_SIZE; j++)
          mem[b][j*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(b * BLOCK_SIZE + j);
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            state    <= BUSY;
            mem_busy <= 1'b1;
            cnt      <= CW'(LATENCY - 1);
            is_write <= mem_write;
            in_range <= {1'b0, mem_addr} < ADDR_LIMIT;
            idx      <= mem_addr[OFF +: IW];
            wdata_q  <= mem_wdata;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= RESP;
            mem_busy  <= 1'b0;
            mem_ready <= 1'b1;
            mem_hit   <= in_range;
            if (!is_write)
              mem_rdata <= in_range ? mem[idx] : '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          mem_hit   <= 1'b0;
          if (is_write && in_range)
            mem[idx] <= wdata_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_main_memory.sv
// Directed bench for l2_main_memory: latency, hit flag, read/write data, request
// dropping while busy, and reset abort.
module tb_l2_main_memory;
  localparam int BW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [BW-1:0] mem_rdata;
  logic          mem_ready;
  logic          mem_hit;
  logic          mem_busy;

  int checks = 0;
  int errors = 0;

  int            lat;
  int            bcnt;
  int            pulses;
  logic          hit_r;
  logic          busy_r;
  logic [BW-1:0] rdata_r;
  logic [BW-1:0] wblk;
  logic [BW-1:0] prev;

  l2_main_memory dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_hit(mem_hit), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pat(input int b);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < 16; j++) v[j*32 +: 32] = 32'(b * 16 + j);
    return v;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; pulses the request for one edge, then waits for the ready pulse
  // and returns one cycle later, in the first IDLE cycle after the pulse.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [BW-1:0] wd);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = wd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    lat = 99; bcnt = 0; hit_r = 1'bx; busy_r = 1'bx; rdata_r = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_busy) bcnt++;
      if (mem_ready) begin
        lat = k; hit_r = mem_hit; busy_r = mem_busy; rdata_r = mem_rdata;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdata", mem_rdata, '0);
    check("rst_ready", BW'(mem_ready), '0);
    check("rst_hit", BW'(mem_hit), '0);
    check("rst_busy", BW'(mem_busy), '0);
    rst = 1'b0;
    @(negedge clk);

    // 1: read block 1
    do_req(1'b1, 1'b0, 32'h40, '0);
    check("t1_latency", BW'(lat), BW'(5));
    check("t1_busy_cycles", BW'(bcnt), BW'(4));
    check("t1_busy_at_ready", BW'(busy_r), '0);
    check("t1_hit", BW'(hit_r), BW'(1));
    check("t1_word0", BW'(rdata_r[31:0]), BW'(32'h10));
    check("t1_word15", BW'(rdata_r[511:480]), BW'(32'h1F));
    check("t1_ready_dropped", BW'(mem_ready), '0);

    // 2: write block 2 then read it back
    for (int j = 0; j < 16; j++) wblk[j*32 +: 32] = 32'h1000 + 32'(j);
    prev = rdata_r;
    do_req(1'b0, 1'b1, 32'h80, wblk);
    check("t2_wr_latency", BW'(lat), BW'(5));
    check("t2_wr_hit", BW'(hit_r), BW'(1));
    check("t2_wr_rdata_kept", rdata_r, prev);
    do_req(1'b1, 1'b0, 32'h80, '0);
    check("t2_rd_hit", BW'(hit_r), BW'(1));
    check("t2_rd_block", rdata_r, wblk);

    // 3: out of range
    do_req(1'b1, 1'b0, 32'h1000, '0);
    check("t3_rd_latency", BW'(lat), BW'(5));
    check("t3_rd_hit", BW'(hit_r), '0);
    check("t3_rd_data", rdata_r, '0);
    do_req(1'b0, 1'b1, 32'h1000, {16{32'hDEAD_BEEF}});
    check("t3_wr_hit", BW'(hit_r), '0);
    do_req(1'b1, 1'b0, 32'h0, '0);
    check("t3_block0", rdata_r, pat(0));

    // 4: read+write together is a write
    prev = rdata_r;
    do_req(1'b1, 1'b1, 32'hC0, {16{32'hAAAA_AAAA}});
    check("t4_rw_hit", BW'(hit_r), BW'(1));
    check("t4_rw_rdata_kept", rdata_r, prev);
    do_req(1'b1, 1'b0, 32'hC0, '0);
    check("t4_block3", rdata_r, {16{32'hAAAA_AAAA}});

    // 5: requests while busy and during ready are ignored; a held request is accepted
    mem_read = 1'b1; mem_addr = 32'h100;
    @(posedge clk); #1;
    mem_read = 1'b0;
    pulses = 0; lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin
        mem_read = 1'b1; mem_addr = 32'h140;
        @(posedge clk); #1;
        mem_read = 1'b0;
        k++;
        @(negedge clk);
      end
      if (mem_ready) begin
        pulses++; lat = k; rdata_r = mem_rdata;
        break;
      end
    end
    check("t5_first_latency", BW'(lat), BW'(5));
    check("t5_first_block", rdata_r, pat(4));
    mem_read = 1'b1; mem_addr = 32'h140;
    @(negedge clk);
    check("t5_not_taken_in_ready", BW'(mem_busy), '0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        pulses++;
        if (lat == 99) begin lat = k; rdata_r = mem_rdata; end
      end
    end
    check("t5_pulses", BW'(pulses), BW'(2));
    check("t5_held_latency", BW'(lat), BW'(5));
    check("t5_held_block", rdata_r, pat(5));

    // 6: reset aborts an in-flight write
    mem_write = 1'b1; mem_addr = 32'h40; mem_wdata = {16{32'h5555_5555}};
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rdata_zero", mem_rdata, '0);
    check("t6_busy_zero", BW'(mem_busy), '0);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    check("t6_no_pulse", BW'(pulses), '0);
    do_req(1'b1, 1'b0, 32'h40, '0);
    check("t6_hit", BW'(hit_r), BW'(1));
    check("t6_block1", rdata_r, pat(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
